// File: rtl/led_matrix_scanner.sv
// Row-scan driver for an LED dot matrix: double-buffered frame intake,
// per-row blanking gap, fixed-dwell row ON phase with PWM column dimming.
module led_matrix_scanner #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DWELL_LOG2 = 10,
    parameter int BLANK_CYC  = 4,
    parameter int BRIGHT_W   = 4
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      enable,
    input  logic [BRIGHT_W-1:0]                       brightness,
    input  logic [ROWS*COLS-1:0]                      frame_data,
    input  logic                                      frame_valid,
    output logic                                      frame_ready,
    output logic [COLS-1:0]                           led_col,
    output logic [ROWS-1:0]                           led_row,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] row_idx,
    output logic                                      frame_start
);

    localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BLANK_W    = $clog2(BLANK_CYC + 1);
    localparam int CNT_W      = (DWELL_LOG2 > BLANK_W) ? DWELL_LOG2 : BLANK_W;
    localparam int DWELL_LAST = (2 ** DWELL_LOG2) - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ON
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [RW-1:0]        r_row, w_row_nxt;
    logic [BRIGHT_W-1:0]  r_bright, w_bright_nxt;
    logic [ROWS*COLS-1:0] r_active, r_shadow, w_active_nxt;
    logic                 r_shadow_full, w_full_nxt;
    logic                 w_capture, w_swap, w_fs_nxt;
    logic [COLS-1:0]      w_bits, w_col_nxt;
    logic [ROWS-1:0]      w_row_oh, w_led_row_nxt;

    // Next-state, buffer handoff and next output values (outputs are registered from these)
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_row_nxt    = r_row;
        w_bright_nxt = r_bright;
        w_fs_nxt     = 1'b0;

        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_row_nxt   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                    w_row_nxt   = '0;
                    w_fs_nxt    = 1'b1;
                end
                S_BLANK: begin
                    if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
                        w_state_nxt  = S_ON;
                        w_cnt_nxt    = '0;
                        w_bright_nxt = brightness;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (r_cnt == CNT_W'(DWELL_LAST)) begin
                        w_state_nxt = S_BLANK;
                        w_cnt_nxt   = '0;
                        if (r_row == RW'(ROWS - 1)) begin
                            w_row_nxt = '0;
                            w_fs_nxt  = 1'b1;
                        end else begin
                            w_row_nxt = r_row + RW'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // Swap only at a frame boundary or while idle; capture only into an empty shadow,
        // so the two can never fire together.
        w_swap       = r_shadow_full && (w_fs_nxt || (r_state == S_IDLE));
        w_capture    = frame_valid && !r_shadow_full;
        w_active_nxt = w_swap ? r_shadow : r_active;
        w_full_nxt   = w_capture ? 1'b1 : (w_swap ? 1'b0 : r_shadow_full);

        w_bits   = '0;
        w_row_oh = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (w_row_nxt == RW'(r)) begin
                w_bits              = w_active_nxt[(ROWS - r) * COLS - 1 -: COLS];
                w_row_oh[ROWS-1-r]  = 1'b1;
            end
        end

        w_led_row_nxt = '0;
        w_col_nxt     = '1;
        if (w_state_nxt == S_ON) begin
            w_led_row_nxt = w_row_oh;
            if (w_cnt_nxt[DWELL_LOG2-1 -: BRIGHT_W] < w_bright_nxt) begin
                w_col_nxt = ~w_bits;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, frame buffers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt         <= '0;
            r_row         <= '0;
            r_bright      <= '0;
            r_active      <= '0;
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            frame_ready   <= 1'b1;
            led_row       <= '0;
            led_col       <= '1;
            row_idx       <= '0;
            frame_start   <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_row         <= w_row_nxt;
            r_bright      <= w_bright_nxt;
            r_active      <= w_active_nxt;
            if (w_capture) begin
                r_shadow <= frame_data;
            end
            r_shadow_full <= w_full_nxt;
            frame_ready   <= ~w_full_nxt;
            led_row       <= w_led_row_nxt;
            led_col       <= w_col_nxt;
            row_idx       <= w_row_nxt;
            frame_start   <= w_fs_nxt;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: directed scenarios plus random traffic,
// checked every cycle against a position-in-frame reference model.
module tb_led_matrix_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DL   = 4;
    localparam int BC   = 2;
    localparam int BW   = 2;
    localparam int RP   = BC + (2 ** DL);   // row period
    localparam int FP   = ROWS * RP;        // frame period
    localparam int PWM_STEP = (2 ** DL) / (2 ** BW);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [BW-1:0] brightness;
    logic [15:0]   frame_data;
    logic          frame_valid;
    logic          frame_ready;
    logic [3:0]    led_col;
    logic [3:0]    led_row;
    logic [1:0]    row_idx;
    logic          frame_start;

    always #5 clk = ~clk;

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DWELL_LOG2(DL), .BLANK_CYC(BC), .BRIGHT_W(BW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .brightness(brightness),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .led_col(led_col), .led_row(led_row), .row_idx(row_idx), .frame_start(frame_start)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // reference model: scanning flag, position within frame, buffers
    bit          m_run;
    int          m_p;
    logic [15:0] m_active, m_shadow;
    bit          m_full;
    int          m_blat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] row_bits(input logic [15:0] f, input int r);
        logic [15:0] t;
        t = f >> ((ROWS - 1 - r) * COLS);
        return t[3:0];
    endfunction

    task automatic model_reset();
        m_run = 0; m_p = 0; m_active = '0; m_shadow = '0; m_full = 0; m_blat = 0;
    endtask

    // advance the model by one clock using the inputs about to be sampled
    task automatic model_edge();
        bit was_full, swap;
        was_full = m_full;
        swap = 0;
        if (!enable) begin
            if (!m_run && was_full) swap = 1;
            m_run = 0;
        end else begin
            if (!m_run) begin
                m_run = 1;
                m_p = 0;
            end else begin
                m_p = (m_p + 1) % FP;
            end
            if (m_p == 0 && was_full) swap = 1;
            if (m_p % RP == BC) m_blat = int'(brightness);
        end
        if (swap) begin
            m_active = m_shadow;
            m_full = 0;
        end
        if (frame_valid && !was_full) begin
            m_shadow = frame_data;
            m_full = 1;
        end
    endtask

    task automatic check_all();
        logic [3:0] e_row, e_col, top;
        int e_idx, r, w;
        bit e_fs;
        e_row = '0; e_col = 4'hF; e_idx = 0; e_fs = 0; top = 4'b1000;
        if (m_run) begin
            r = m_p / RP;
            w = m_p % RP;
            e_idx = r;
            e_fs = (m_p == 0);
            if (w >= BC) begin
                e_row = top >> r;
                if ((w - BC) / PWM_STEP < m_blat) e_col = ~row_bits(m_active, r);
            end
        end
        chk("led_row", 32'(led_row), 32'(e_row));
        chk("led_col", 32'(led_col), 32'(e_col));
        chk("row_idx", 32'(row_idx), 32'(e_idx));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("frame_ready", 32'(frame_ready), 32'(!m_full));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic tick_to(input int pos);
        int b;
        b = 0;
        while (!(m_run && m_p == pos) && b < 4 * FP) begin
            tick();
            b++;
        end
        if (!(m_run && m_p == pos)) begin
            n_checks++;
            n_fail++;
            $error("FAIL tick_to_bound observed=timeout expected=pos%0d", pos);
        end
    endtask

    // assert reset between edges and check outputs go dark without a clock
    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_led_row", 32'(led_row), 32'h0);
        chk("rst_led_col", 32'(led_col), 32'hF);
        chk("rst_frame_ready", 32'(frame_ready), 32'h1);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        chk("rst_row_idx", 32'(row_idx), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int lit;
        bit acc;
        reset_n = 1'b0; enable = 1'b0; brightness = 2'd3;
        frame_data = '0; frame_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("init_led_row", 32'(led_row), 32'h0);
        chk("init_led_col", 32'(led_col), 32'hF);
        chk("init_frame_ready", 32'(frame_ready), 32'h1);
        chk("init_row_idx", 32'(row_idx), 32'h0);
        reset_n = 1'b1;

        // 1: scan with empty frame
        enable = 1'b1;
        tick();
        chk("t1_first_frame_start", 32'(frame_start), 32'h1);
        tick_to(2);
        chk("t1_row0_sel", 32'(led_row), 32'h8);
        tick_to(RP + 2);
        chk("t1_row1_sel", 32'(led_row), 32'h4);
        tick_to(FP - 1);
        chk("t1_row3_sel", 32'(led_row), 32'h1);

        // 2: load F0A5 mid-frame, appears only at next frame
        tick_to(30);
        frame_data = 16'hF0A5; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0; frame_data = 16'($urandom);
        chk("t2_ready_low", 32'(frame_ready), 32'h0);
        tick_to(RP + 2);
        chk("t2_old_frame_row1", 32'(led_col), 32'hF);
        tick_to(0);
        chk("t2_swap_ready", 32'(frame_ready), 32'h1);
        tick_to(2);
        chk("t2_row0_lit", 32'(led_col), 32'h0);
        tick_to(2 + 12);
        chk("t2_row0_dark_cnt12", 32'(led_col), 32'hF);
        tick_to(2 * RP + 2);
        chk("t2_row2_lit", 32'(led_col), 32'h5);
        tick_to(3 * RP + 2 + 11);
        chk("t2_row3_lit_cnt11", 32'(led_col), 32'hA);

        // 3: second frame offered while shadow full waits for swap
        tick_to(60);
        frame_data = 16'h1234; frame_valid = 1'b1;
        tick();
        frame_data = 16'h5A5A;
        tick();
        chk("t3_ready_while_full", 32'(frame_ready), 32'h0);
        tick_to(0);
        chk("t3_ready_after_swap", 32'(frame_ready), 32'h1);
        tick();
        frame_valid = 1'b0;
        chk("t3_accepted_next", 32'(frame_ready), 32'h0);
        tick_to(2);
        chk("t3_row0_frameB", 32'(led_col), 32'hE);

        // 4: brightness change mid-row applies on the next row only
        brightness = 2'd0;
        tick_to(2 * RP + 2 + 5);
        chk("t4_bright0_dark", 32'(led_col), 32'hF);
        brightness = 2'd2;
        tick_to(3 * RP - 1);
        chk("t4_row2_still_dark", 32'(led_col), 32'hF);
        tick_to(3 * RP + 1);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led_col !== 4'hF) lit++;
        end
        chk("t4_row3_lit_cycles", 32'(lit), 32'd8);

        // 5: enable dropped during row 2 ON, then restarted
        brightness = 2'd3;
        tick_to(2 * RP + 2 + 3);
        enable = 1'b0;
        tick();
        chk("t5_dark_row", 32'(led_row), 32'h0);
        chk("t5_dark_col", 32'(led_col), 32'hF);
        repeat (3) tick();
        enable = 1'b1;
        tick();
        chk("t5_restart_fs", 32'(frame_start), 32'h1);
        tick();
        chk("t5_still_blank", 32'(led_row), 32'h0);
        tick();
        chk("t5_row0_after_blank", 32'(led_row), 32'h8);

        // 6: reset with a pending shadow discards it
        frame_data = 16'hFFFF; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        chk("t6_shadow_full", 32'(frame_ready), 32'h0);
        tick_to(40);
        async_reset();
        tick_to(2);
        chk("t6_active_cleared", 32'(led_col), 32'hF);
        tick_to(2 * RP + 5);
        chk("t6_shadow_dropped", 32'(led_col), 32'hF);

        // random traffic: frames, brightness, enable toggles
        for (int i = 0; i < 1500; i++) begin
            if (!frame_valid) begin
                frame_data = 16'($urandom);
                if ($urandom_range(0, 24) == 0) frame_valid = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) brightness = BW'($urandom);
            if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 4) == 0) enable = 1'b1;
            acc = frame_valid && !m_full;
            tick();
            if (acc) frame_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
